gate_sweep_ctrl: RTL and testbench
==================================

# gate_sweep_ctrl

Sequencer that exhaustively exercises a small combinational logic gate (the 3-input OR gate and its siblings in the logic_gates library) in hardware. On a start pulse it drives every input combination onto the gate in ascending binary order and holds each for a programmable dwell time. It captures the gate output into a truth-table register and optionally checks it against an expected table. It sits between a lab/self-test top level and one gate instance whose inputs it owns.

## Interface
- N_IN, default 3: gate input count; sweep length is 2^N_IN vectors.
- DWELL, default 2: cycles each vector is held; legal range 1..255.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active-low. One clock; reset is synchronous and active-low.
- start  in  1  sweep request; honoured only in IDLE.
- expected  in  2^N_IN  expected truth table; bit v holds the expected output for input vector v. Latched on the accepted start.
- gate_out  in  1  output of the gate under control.
- vec  out  N_IN  gate input vector. Bit N_IN-1 drives the first gate input, for example x.
- busy  out  1  high while sweeping.
- done  out  1  one-cycle pulse when a sweep completes.
- table  out  2^N_IN  captured truth table; held until the next accepted start.
- pass  out  1  sweep matched `expected`.
- fail_idx  out  N_IN  lowest vector index that mismatched.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN when start=1.
  - On the same edge: vec←0, dwell counter←0, table←0, exp_q←expected, and the mismatch flag and fail_idx are cleared.
- RUN:
  - The dwell counter counts 0..DWELL-1.
  - On the edge where the counter equals DWELL-1: table[vec]←gate_out.
    - If vec is all-ones, go to DONE and set vec←0.
    - Otherwise vec←vec+1 and counter←0.
- DONE → IDLE unconditionally after one cycle.
- start is ignored in RUN and in DONE; it is not queued.
- vec is 0 whenever the FSM is not in RUN.
- The vector counter is N_IN bits wide and terminates on all-ones. It never wraps.
- Outputs: busy=(state==RUN), done=(state==DONE).

## Timing
- Reset values: state IDLE, vec=0, busy=0, done=0, table=0, pass=0, fail_idx=0, dwell counter 0.
- start is sampled at edge E0. busy=1 and vec=0 from E0 onward.
- vec=v is driven for exactly DWELL cycles, from E0+v·DWELL to E0+(v+1)·DWELL.
- gate_out for vector v is sampled on edge E0+(v+1)·DWELL. This allows DWELL-1 cycles of settle time after the first cycle.
- done is high in the cycle following edge E0+2^N_IN·DWELL; busy is 0 in that cycle.
  - Default parameters: done is high in the cycle after edge E0+16.
- table, pass and fail_idx are final when done is high and stay stable until the next accepted start.
- The earliest new start is accepted on the edge ending the DONE cycle+1, i.e. from IDLE. No back-to-back start from DONE.
- Reset mid-sweep: on the next edge with rst_n=0 every register returns to its reset value. No done pulse is produced.

## Configuration
- Macro GATE_SWEEP_COMPARE_EN.
- Defined:
  - On each sample, if gate_out≠exp_q[vec] and no mismatch has been recorded yet, record fail_idx←vec and set the mismatch flag.
  - On entry to DONE: pass←!mismatch. pass is cleared on the next accepted start.
- Undefined:
  - exp_q, the mismatch flag and the compare logic are not built.
  - pass and fail_idx are tied to 0. The expected port remains in the interface and is ignored.
  - Sequencing, table capture and timing are identical to the defined case.

## Test plan
- Correct OR model, expected=8'hFE, default parameters, start pulse at E0 → vec steps 0..7, each held 2 cycles. done is a single pulse one cycle after E0+16. table=8'hFE, pass=1, fail_idx=0.
- Faulty model with output stuck at 0 for vectors 5 and 6, expected=8'hFE → table=8'h9E, pass=0, fail_idx=5.
- start held high throughout a sweep, and asserted again during DONE → exactly one sweep. Next sweep starts only once the FSM is in IDLE, and table is cleared at that start.
- rst_n low for one edge while vec=3 → next cycle busy=0, vec=0, table=0, pass=0. No done pulse.
- DWELL=1, N_IN=2, AND model, expected=4'h8 → done one cycle after E0+4, table=4'h8, pass=1.
- Build without GATE_SWEEP_COMPARE_EN, faulty model → table captures the faulty values and sweep timing is unchanged. pass=0 and fail_idx=0 at all times.

Source files
------------

// File: rtl/gate_sweep_ctrl.sv
// Exhaustive input sweeper for a small combinational gate: steps every input vector,
// holds each for DWELL cycles and captures the output into a truth table.
// Optional expected-table comparison is built when GATE_SWEEP_COMPARE_EN is defined.
module gate_sweep_ctrl #(
  parameter int N_IN  = 3,
  parameter int DWELL = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 start_i,
  input  logic [(1<<N_IN)-1:0] expected_i,
  input  logic                 gate_out_i,
  output logic [N_IN-1:0]      vec_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [(1<<N_IN)-1:0] table_o,
  output logic                 pass_o,
  output logic [N_IN-1:0]      fail_idx_o
);
  localparam int         NV      = 1 << N_IN;
  localparam logic [7:0] DW_LAST = 8'(DWELL - 1);

  if (DWELL < 1 || DWELL > 255) begin : g_bad_dwell
    $error("gate_sweep_ctrl: DWELL must be in 1..255");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [NV-1:0]   table_q, table_d;
  logic            accept;
  logic            sample;
  logic            last_vec;

  assign accept   = (state_q == S_IDLE) && start_i;
  // Output is captured on the final cycle of each dwell window.
  assign sample   = (state_q == S_RUN) && (cnt_q == DW_LAST);
  assign last_vec = &vec_q;

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    table_d = table_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_RUN;
          vec_d   = '0;
          cnt_d   = '0;
          table_d = '0;
        end
      end
      S_RUN: begin
        if (sample) begin
          table_d[vec_q] = gate_out_i;
          cnt_d          = '0;
          if (last_vec) begin
            state_d = S_DONE;
            vec_d   = '0;
          end else begin
            vec_d = vec_q + N_IN'(1);
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        vec_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      table_q <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      table_q <= table_d;
    end
  end

  assign vec_o   = vec_q;
  assign busy_o  = (state_q == S_RUN);
  assign done_o  = (state_q == S_DONE);
  assign table_o = table_q;

`ifdef GATE_SWEEP_COMPARE_EN
  logic [NV-1:0]   exp_q, exp_d;
  logic            mis_q, mis_d;
  logic [N_IN-1:0] fidx_q, fidx_d;
  logic            pass_q, pass_d;
  logic            miss_now;

  assign miss_now = sample && (gate_out_i != exp_q[vec_q]);

  always_comb begin
    exp_d  = exp_q;
    mis_d  = mis_q;
    fidx_d = fidx_q;
    pass_d = pass_q;
    if (accept) begin
      exp_d  = expected_i;
      mis_d  = 1'b0;
      fidx_d = '0;
      pass_d = 1'b0;
    end else if (sample) begin
      // Only the first mismatch is recorded; later ones keep the lowest index.
      if (miss_now && !mis_q) begin
        mis_d  = 1'b1;
        fidx_d = vec_q;
      end
      if (last_vec) pass_d = !(mis_q || miss_now);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      exp_q  <= '0;
      mis_q  <= 1'b0;
      fidx_q <= '0;
      pass_q <= 1'b0;
    end else begin
      exp_q  <= exp_d;
      mis_q  <= mis_d;
      fidx_q <= fidx_d;
      pass_q <= pass_d;
    end
  end

  assign pass_o     = pass_q;
  assign fail_idx_o = fidx_q;
`else
  logic unused_cmp;
  assign unused_cmp = ^{expected_i, accept};
  assign pass_o     = 1'b0;
  assign fail_idx_o = '0;
`endif

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Self-checking bench for gate_sweep_ctrl: default (3 inputs, dwell 2) and small
// (2 inputs, dwell 1) instances driven by a cycle-accurate gate stimulus.
module tb_gate_sweep_ctrl;
  logic clk, rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic       m_start, m_gate, m_busy, m_done, m_pass;
  logic [7:0] m_exp, m_table;
  logic [2:0] m_vec, m_fidx;

  logic       s_start, s_gate, s_busy, s_done, s_pass;
  logic [3:0] s_exp, s_table;
  logic [1:0] s_vec, s_fidx;

  gate_sweep_ctrl #(.N_IN(3), .DWELL(2)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(m_start), .expected_i(m_exp),
    .gate_out_i(m_gate), .vec_o(m_vec), .busy_o(m_busy), .done_o(m_done),
    .table_o(m_table), .pass_o(m_pass), .fail_idx_o(m_fidx));

  gate_sweep_ctrl #(.N_IN(2), .DWELL(1)) u_small (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(s_start), .expected_i(s_exp),
    .gate_out_i(s_gate), .vec_o(s_vec), .busy_o(s_busy), .done_o(s_done),
    .table_o(s_table), .pass_o(s_pass), .fail_idx_o(s_fidx));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference: pass when every vector matches; fail index is the lowest mismatch.
  function automatic logic ref_pass(input logic [7:0] g, input logic [7:0] e, input int nv);
    logic r;
    r = 1'b0;
`ifdef GATE_SWEEP_COMPARE_EN
    r = 1'b1;
    for (int v = 0; v < nv; v++) if (g[v] !== e[v]) r = 1'b0;
`endif
    return r;
  endfunction

  function automatic int ref_fidx(input logic [7:0] g, input logic [7:0] e, input int nv);
`ifdef GATE_SWEEP_COMPARE_EN
    for (int v = 0; v < nv; v++) if (g[v] !== e[v]) return v;
`endif
    return 0;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({m_busy, m_done, m_vec, m_table, m_pass, m_fidx} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_main: got busy=%b done=%b vec=%0d table=%h pass=%b fidx=%0d required all zero",
               m_busy, m_done, m_vec, m_table, m_pass, m_fidx);
    end
    n_checks++;
    if ({s_busy, s_done, s_vec, s_table, s_pass, s_fidx} !== 10'h0) begin
      n_fail++;
      $display("FAIL reset_small: got busy=%b done=%b vec=%0d table=%h pass=%b fidx=%0d required all zero",
               s_busy, s_done, s_vec, s_table, s_pass, s_fidx);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // One full sweep on the default instance. Gate output is wrong except in the
  // last cycle of each dwell window, so early or late sampling is visible.
  task automatic test_sweep(input logic [7:0] g, input logic [7:0] e, input bit hold);
    logic       ep;
    logic [2:0] ef;
    ep = ref_pass(g, e, 8);
    ef = 3'(ref_fidx(g, e, 8));
    m_exp   = e;
    m_start = 1'b1;
    @(posedge clk); #1;
    if (!hold) m_start = 1'b0;
    m_exp = ~e;
    for (int k = 0; k < 16; k++) begin
      m_gate = (k % 2 == 1) ? g[k/2] : ~g[k/2];
      n_checks++;
      if (m_vec !== 3'(k / 2)) begin
        n_fail++;
        $display("FAIL sweep_vec: cycle %0d got %0d required %0d", k, m_vec, k / 2);
      end
      n_checks++;
      if (m_busy !== 1'b1 || m_done !== 1'b0 || m_pass !== 1'b0) begin
        n_fail++;
        $display("FAIL sweep_status: cycle %0d got busy=%b done=%b pass=%b required 1 0 0",
                 k, m_busy, m_done, m_pass);
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (m_done !== 1'b1 || m_busy !== 1'b0 || m_vec !== 3'd0) begin
      n_fail++;
      $display("FAIL done_cycle: got done=%b busy=%b vec=%0d required 1 0 0", m_done, m_busy, m_vec);
    end
    n_checks++;
    if (m_table !== g || m_pass !== ep || m_fidx !== ef) begin
      n_fail++;
      $display("FAIL result: got table=%h pass=%b fidx=%0d required %h %b %0d",
               m_table, m_pass, m_fidx, g, ep, ef);
    end
    @(posedge clk); #1;
    n_checks++;
    if (m_done !== 1'b0 || m_busy !== 1'b0 || m_table !== g || m_pass !== ep || m_fidx !== ef) begin
      n_fail++;
      $display("FAIL after_done: got done=%b busy=%b table=%h pass=%b fidx=%0d required 0 0 %h %b %0d",
               m_done, m_busy, m_table, m_pass, m_fidx, g, ep, ef);
    end
  endtask

  // Entered from the IDLE cycle after a held-start sweep: start is still high.
  task automatic test_back_to_back();
    m_gate = 1'b1;
    @(posedge clk); #1;
    m_start = 1'b0;
    n_checks++;
    if (m_busy !== 1'b1 || m_vec !== 3'd0 || m_table !== 8'h00) begin
      n_fail++;
      $display("FAIL restart: got busy=%b vec=%0d table=%h required 1 0 00", m_busy, m_vec, m_table);
    end
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (m_done !== (i == 15)) begin
        n_fail++;
        $display("FAIL restart_done: step %0d got %b required %b", i, m_done, (i == 15));
      end
    end
    n_checks++;
    if (m_table !== 8'hFF) begin
      n_fail++;
      $display("FAIL restart_table: got %h required ff", m_table);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    logic [7:0] g;
    bit         seen_done;
    g = 8'hFE;
    m_exp   = g;
    m_start = 1'b1;
    @(posedge clk); #1;
    m_start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      m_gate = (k % 2 == 1) ? g[k/2] : ~g[k/2];
      @(posedge clk); #1;
    end
    n_checks++;
    if (m_vec !== 3'd3 || m_table !== 8'h06) begin
      n_fail++;
      $display("FAIL pre_reset: got vec=%0d table=%h required 3 06", m_vec, m_table);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_checks++;
    if (m_busy !== 1'b0 || m_vec !== 3'd0 || m_table !== 8'h00 || m_pass !== 1'b0 ||
        m_fidx !== 3'd0 || m_done !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got busy=%b vec=%0d table=%h pass=%b fidx=%0d done=%b required all zero",
               m_busy, m_vec, m_table, m_pass, m_fidx, m_done);
    end
    seen_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (m_done !== 1'b0 || m_busy !== 1'b0) seen_done = 1'b1;
    end
    n_checks++;
    if (seen_done) begin
      n_fail++;
      $display("FAIL reset_no_done: got activity=1 required 0");
    end
  endtask

  task automatic test_small(input logic [3:0] g, input logic [3:0] e);
    logic       ep;
    logic [1:0] ef;
    ep = ref_pass({4'h0, g}, {4'h0, e}, 4);
    ef = 2'(ref_fidx({4'h0, g}, {4'h0, e}, 4));
    s_exp   = e;
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    s_exp   = ~e;
    for (int k = 0; k < 4; k++) begin
      s_gate = g[k];
      n_checks++;
      if (s_vec !== 2'(k) || s_busy !== 1'b1 || s_done !== 1'b0) begin
        n_fail++;
        $display("FAIL small_step: cycle %0d got vec=%0d busy=%b done=%b required %0d 1 0",
                 k, s_vec, s_busy, s_done, k);
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (s_done !== 1'b1 || s_busy !== 1'b0 || s_table !== g || s_pass !== ep || s_fidx !== ef) begin
      n_fail++;
      $display("FAIL small_result: got done=%b busy=%b table=%h pass=%b fidx=%0d required 1 0 %h %b %0d",
               s_done, s_busy, s_table, s_pass, s_fidx, g, ep, ef);
    end
    @(posedge clk); #1;
    n_checks++;
    if (s_done !== 1'b0) begin
      n_fail++;
      $display("FAIL small_pulse: got done=%b required 0", s_done);
    end
  endtask

  initial begin
    logic [7:0] g, e;
    clk = 1'b0; rst_n = 1'b0;
    m_start = 1'b0; m_exp = 8'h00; m_gate = 1'b0;
    s_start = 1'b0; s_exp = 4'h0;  s_gate = 1'b0;
    test_reset();
    test_sweep(8'hFE, 8'hFE, 1'b0);
    test_sweep(8'h9E, 8'hFE, 1'b0);
    for (int i = 0; i < 4; i++) begin
      g = 8'($urandom);
      e = ($urandom_range(0, 1) == 1) ? g : 8'($urandom);
      test_sweep(g, e, 1'b0);
    end
    test_sweep(8'hFE, 8'hFE, 1'b1);
    test_back_to_back();
    test_sweep(8'hFE, 8'hFE, 1'b0);
    test_mid_reset();
    test_small(4'h8, 4'h8);
    test_small(4'h8, 4'hC);
    test_small(4'($urandom), 4'($urandom));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
